msx_mouse_reader: RTL and testbench
===================================

Name: msx_mouse_reader

Overview:
- Host-side initiator for the MSX joystick-port mouse protocol: drives the port strobe (pin 8) and reads back four data nibbles plus button states.
- Assembles the nibbles into signed X/Y deltas and buttons.
- Runs on a periodic poll or an on-demand request.
- Sits opposite the port-side mouse responder (ps2mouse); used for loopback verification and by future host-side peripherals that consume MSX-protocol mice on the joystick port.

Parameters:
- SETTLE, 64, clocks per strobe phase; data is sampled at the end of each phase (~3 us at 21.48 MHz); legal range ≥2.
- POLL, 357955, clocks between auto-poll sequence starts (~60 Hz at 21.48 MHz); must exceed 4*SETTLE+1 and the device nibble-index timeout.

Ports:
- clk  in  1  system clock (clk_sys domain)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  auto-poll enable
- req  in  1  single-cycle read request
- data  in  6  port pins; [5:4] buttons (active-low, [4]=left), [3:0] nibble (true polarity)
- strobe  out  1  port pin 8 drive; idles low
- busy  out  1  sequence in progress
- dx  out  8  X delta, two's complement
- dy  out  8  Y delta, two's complement
- btn  out  2  buttons, active-high; [0]=left, [1]=right
- present  out  1  mouse detected on last sequence
- valid  out  1  one-cycle pulse when dx/dy/btn/present update

Behaviour:
- Reset (async, active-high): strobe=0, busy=0, dx=0, dy=0, btn=0, present=0, valid=0, poll counter=0, phase=0, FSM=IDLE.
- FSM states: IDLE, PHASE, DONE.
- Poll counter:
  - Increments every clk while enable=1.
  - At POLL-1 it wraps to 0 and raises an internal start.
  - Held at 0 while enable=0.
  - Keeps counting during a sequence.
- Start condition: (req | poll start) while in IDLE. At that edge (E0): strobe←1, busy←1, phase←0, phase counter←0, FSM→PHASE.
- Overlapping triggers:
  - req and poll start on the same cycle produce one sequence.
  - req or poll start while busy=1 is ignored and not queued.
- PHASE:
  - Counter counts 0..SETTLE-1.
  - At the edge where the counter equals SETTLE-1, data[3:0] is captured into nibble slot[phase].
  - Slot order: 0=X[7:4], 1=X[3:0], 2=Y[7:4], 3=Y[3:0].
  - On that same edge, for phase<3: strobe toggles, phase increments, counter clears.
  - Strobe levels per phase: 1, 0, 1, 0.
- Phase-3 sample edge (E0+4*SETTLE):
  - data[5:4] is also captured.
  - Raw check: raw=1 if every one of the four samples had data==6'h3F, including bits 5:4 of each phase.
  - present←~raw.
  - If present: dx←{s0,s1}, dy←{s2,s3}, btn←~{data[5],data[4]}. Otherwise dx=0, dy=0, btn=0.
  - valid←1 and busy←0; FSM→DONE.
  - strobe remains 0.
- DONE: valid←0 and FSM→IDLE. Next start is accepted from the following cycle.
- Timing:
  - valid is high exactly in cycle E0+4*SETTLE+1.
  - busy is high for 4*SETTLE cycles.
  - Start-to-start minimum spacing is 4*SETTLE+2 cycles.
- Outputs hold their values between sequences. No arithmetic is performed on deltas; they pass through as 8-bit two's complement.
- Reset mid-sequence: everything returns to reset values immediately, with strobe low. The device nibble index recovers through its own timeout, since POLL exceeds it.
- Changing enable mid-sequence does not abort the sequence.

Test Plan:
1. req pulse, SETTLE=4; responder model presents nibbles 0xF,0xE,0x0,0x5 with data[5:4]=2'b10 -> strobe 1,0,1,0 with each level lasting 4 cycles; valid at E0+17; dx=8'hFE, dy=8'h05, btn=2'b01, present=1.
2. Data stuck at 6'h3F (no device), req -> valid pulses; present=0, dx=0, dy=0, btn=0.
3. enable=1, POLL=100, SETTLE=4 -> strobe rising edges every 100 cycles; one valid per sequence; enable=0 produces no further strobe activity.
4. req reasserted while busy=1, then req together with a poll start in IDLE -> exactly one sequence each time; no queued extra sequence.
5. reset asserted at phase 2 -> strobe, busy, and valid go low asynchronously; dx/dy/btn clear; after release, a new req completes normally with correct values.
6. Nibbles 0x8,0x0,0x7,0xF with buttons 2'b00 -> dx=8'h80, dy=8'h7F, btn=2'b11 (sign extremes and both buttons pressed).

Source files
------------

// File: rtl/msx_mouse_reader.sv
// Host-side MSX joystick-port mouse reader: strobes pin 8 through four phases,
// samples one nibble per phase and assembles signed X/Y deltas plus buttons.
`timescale 1ns / 1ps

module msx_mouse_reader #(
    parameter int unsigned SETTLE = 64,
    parameter int unsigned POLL   = 357955
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req,
    input  logic [5:0] data,
    output logic       strobe,
    output logic       busy,
    output logic [7:0] dx,
    output logic [7:0] dy,
    output logic [1:0] btn,
    output logic       present,
    output logic       valid
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned PW = (POLL > 1) ? $clog2(POLL) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [PW-1:0] POLL_LAST   = PW'(POLL - 1);

    typedef enum logic [1:0] {StIdle, StPhase, StDone} state_t;

    state_t        state;
    logic [PW-1:0] poll_cnt;
    logic [CW-1:0] cnt;
    logic [1:0]    phase;
    logic [3:0]    slot [3];
    logic          all_ones;
    logic          poll_start;
    logic          sample_ones;
    logic          last_raw;

    assign poll_start  = enable && (poll_cnt == POLL_LAST);
    assign sample_ones = (data == 6'h3F);
    // No device when every sample of the sequence, buttons included, read all-ones.
    assign last_raw    = all_ones & sample_ones;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poll_cnt <= '0;
        end else if (!enable || poll_cnt == POLL_LAST) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= StIdle;
            strobe   <= 1'b0;
            busy     <= 1'b0;
            dx       <= '0;
            dy       <= '0;
            btn      <= '0;
            present  <= 1'b0;
            valid    <= 1'b0;
            cnt      <= '0;
            phase    <= '0;
            all_ones <= 1'b0;
            for (int i = 0; i < 3; i++) slot[i] <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req || poll_start) begin
                        strobe   <= 1'b1;
                        busy     <= 1'b1;
                        phase    <= '0;
                        cnt      <= '0;
                        all_ones <= 1'b1;
                        state    <= StPhase;
                    end
                end
                StPhase: begin
                    if (cnt != SETTLE_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (phase != 2'd3) begin
                        slot[phase] <= data[3:0];
                        all_ones    <= all_ones & sample_ones;
                        strobe      <= ~strobe;
                        phase       <= phase + 2'd1;
                        cnt         <= '0;
                    end else begin
                        present <= ~last_raw;
                        if (!last_raw) begin
                            dx  <= {slot[0], slot[1]};
                            dy  <= {slot[2], data[3:0]};
                            btn <= ~data[5:4];
                        end else begin
                            dx  <= '0;
                            dy  <= '0;
                            btn <= '0;
                        end
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= StDone;
                    end
                end
                StDone: begin
                    valid <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_msx_mouse_reader.sv
// Directed bench for msx_mouse_reader with a small port-side responder model.
`timescale 1ns / 1ps

module tb_msx_mouse_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       req;
    logic [5:0] data;
    logic       strobe;
    logic       busy;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [1:0] btn;
    logic       present;
    logic       valid;

    int checks = 0;
    int errors = 0;

    msx_mouse_reader #(
        .SETTLE(4),
        .POLL  (100)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .req    (req),
        .data   (data),
        .strobe (strobe),
        .busy   (busy),
        .dx     (dx),
        .dy     (dy),
        .btn    (btn),
        .present(present),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // Responder: nibble index restarts when a sequence begins, advances per strobe toggle.
    logic [3:0] nib [4];
    logic [1:0] bsel;
    logic       nodev;
    int         idx = 0;
    logic       prev_s = 1'b0;
    logic       prev_b = 1'b0;

    always @(negedge clk) begin
        if (busy && !prev_b) idx = 0;
        else if (strobe != prev_s && idx < 3) idx = idx + 1;
        prev_s = strobe;
        prev_b = busy;
        data   = nodev ? 6'h3F : {bsel, nib[idx]};
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_req;
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 100) begin
            tick();
            n++;
        end
        chk(tag, {7'd0, valid}, 8'd1);
    endtask

    task automatic set_nib(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] d, input logic [1:0] bs);
        nib[0] = a;
        nib[1] = b;
        nib[2] = c;
        nib[3] = d;
        bsel   = bs;
    endtask

    initial begin
        int rises;
        int vals;
        int first;
        int shigh;
        logic pb;

        reset  = 1'b1;
        enable = 1'b0;
        req    = 1'b0;
        nodev  = 1'b0;
        set_nib(4'hF, 4'hE, 4'h0, 4'h5, 2'b10);
        repeat (3) tick();
        chk("rst_strobe", {7'd0, strobe}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_dx", dx, 8'h00);
        chk("rst_dy", dy, 8'h00);
        chk("rst_btn", {6'd0, btn}, 8'd0);
        chk("rst_present", {7'd0, present}, 8'd0);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        reset = 1'b0;
        tick();

        // 1: strobe pattern 1,0,1,0 of 4 cycles each, valid right after the last phase
        start_req();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("t1_strobe_%0d", k), {7'd0, strobe},
                {7'd0, (k < 4) || (k >= 8 && k < 12)});
            chk($sformatf("t1_busy_%0d", k), {7'd0, busy}, 8'd1);
            tick();
        end
        chk("t1_valid", {7'd0, valid}, 8'd1);
        chk("t1_busy_end", {7'd0, busy}, 8'd0);
        chk("t1_dx", dx, 8'hFE);
        chk("t1_dy", dy, 8'h05);
        chk("t1_btn", {6'd0, btn}, 8'd1);
        chk("t1_present", {7'd0, present}, 8'd1);
        tick();
        chk("t1_valid_drop", {7'd0, valid}, 8'd0);

        // 2: no device
        nodev = 1'b1;
        start_req();
        wait_valid("t2_valid");
        chk("t2_present", {7'd0, present}, 8'd0);
        chk("t2_dx", dx, 8'h00);
        chk("t2_dy", dy, 8'h00);
        chk("t2_btn", {6'd0, btn}, 8'd0);
        tick();
        nodev = 1'b0;

        // 3: auto-poll every 100 cycles, then disabled
        set_nib(4'hA, 4'h5, 4'h3, 4'hC, 2'b11);
        enable = 1'b1;
        rises  = 0;
        vals   = 0;
        first  = -1;
        pb     = busy;
        for (int t = 1; t <= 350; t++) begin
            tick();
            if (busy && !pb) begin
                rises++;
                if (first < 0) first = t;
            end
            if (valid) vals++;
            pb = busy;
        end
        chk("t3_first_start", first[7:0], 8'd100);
        chk("t3_starts", rises[7:0], 8'd3);
        chk("t3_valids", vals[7:0], 8'd3);
        chk("t3_dx", dx, 8'hA5);
        chk("t3_dy", dy, 8'h3C);
        chk("t3_btn", {6'd0, btn}, 8'd0);
        enable = 1'b0;
        rises  = 0;
        shigh  = 0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (busy && !pb) rises++;
            if (strobe) shigh++;
            pb = busy;
        end
        chk("t3_off_starts", rises[7:0], 8'd0);
        chk("t3_off_strobe", shigh[7:0], 8'd0);

        // 4a: req while busy is dropped
        set_nib(4'h1, 4'h2, 4'h3, 4'h4, 2'b01);
        start_req();
        repeat (4) tick();
        start_req();
        rises = 0;
        vals  = 0;
        pb    = busy;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (busy && !pb) rises++;
            if (valid) vals++;
            pb = busy;
        end
        chk("t4a_extra_starts", rises[7:0], 8'd0);
        chk("t4a_valids", vals[7:0], 8'd1);
        chk("t4a_dx", dx, 8'h12);
        chk("t4a_btn", {6'd0, btn}, 8'd2);

        // 4b: req coincident with a poll start gives one sequence
        set_nib(4'h9, 4'h9, 4'h6, 4'h6, 2'b11);
        enable = 1'b1;
        repeat (99) tick();
        start_req();
        chk("t4b_busy", {7'd0, busy}, 8'd1);
        enable = 1'b0;
        rises  = 0;
        vals   = 0;
        pb     = busy;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (busy && !pb) rises++;
            if (valid) vals++;
            pb = busy;
        end
        chk("t4b_extra_starts", rises[7:0], 8'd0);
        chk("t4b_valids", vals[7:0], 8'd1);
        chk("t4b_dy", dy, 8'h66);

        // 5: async reset during phase 2, then a clean sequence
        set_nib(4'h3, 4'hC, 4'hA, 4'h1, 2'b01);
        start_req();
        repeat (8) tick();
        chk("t5_pre_strobe", {7'd0, strobe}, 8'd1);
        reset = 1'b1;
        #1;
        chk("t5_strobe", {7'd0, strobe}, 8'd0);
        chk("t5_busy", {7'd0, busy}, 8'd0);
        chk("t5_valid", {7'd0, valid}, 8'd0);
        chk("t5_dx", dx, 8'h00);
        chk("t5_dy", dy, 8'h00);
        chk("t5_btn", {6'd0, btn}, 8'd0);
        reset = 1'b0;
        repeat (2) tick();
        start_req();
        wait_valid("t5_valid_after");
        chk("t5_dx_after", dx, 8'h3C);
        chk("t5_dy_after", dy, 8'hA1);
        chk("t5_btn_after", {6'd0, btn}, 8'd2);
        chk("t5_present_after", {7'd0, present}, 8'd1);
        tick();

        // 6: sign extremes, both buttons pressed
        set_nib(4'h8, 4'h0, 4'h7, 4'hF, 2'b00);
        start_req();
        wait_valid("t6_valid");
        chk("t6_dx", dx, 8'h80);
        chk("t6_dy", dy, 8'h7F);
        chk("t6_btn", {6'd0, btn}, 8'd3);
        chk("t6_present", {7'd0, present}, 8'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
